// File: rtl/mult_control_n.sv
`default_nettype none
// ============================================================================
//  Module      : mult_control_n
//  Description : Sequencer for a slice-serial multiplier. Walks every
//                (A slice, B slice) pair once, driving slice selects, the
//                partial-product shift and accumulator enable/clear, then
//                pulses done for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_control_n #(
    parameter int SLICE_W = 4,
    parameter int NA      = 2,
    parameter int NB      = 2,
    localparam int AW = (NA > 1) ? $clog2(NA) : 1,
    localparam int BW = (NB > 1) ? $clog2(NB) : 1,
    localparam int SW = ((NA + NB - 1) > 1) ? $clog2(NA + NB - 1) : 1
) (
    input  logic          clk,
    input  logic          reset_a,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] a_sel,
    output logic [BW-1:0] b_sel,
    output logic [SW-1:0] shift_sel,
    output logic [2:0]    state_out,
    output logic          done,
    output logic          busy,
    output logic          clk_ena,
    output logic          sclr_n
);

    // Total number of partial products, and the counter width to index them.
    localparam int NP = NA * NB;
    localparam int KW = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [KW-1:0] K_PENULT = KW'(NP - 2);
    localparam logic [AW-1:0] A_LAST   = AW'(NA - 1);

    // Reject parameter sets that cannot describe a multi-cycle multiplication.
    generate
        if (SLICE_W < 1 || NA < 1 || NB < 1 || NP < 2) begin : g_bad_params
            $error("mult_control_n: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        LSB       = 3'b001,
        MID       = 3'b010,
        MSB       = 3'b011,
        CALC_DONE = 3'b100,
        ERR       = 3'b101
    } state_t;

    state_t        state;
    logic [KW-1:0] k;        // product index, a_cnt/b_cnt are its mod/div split
    logic [AW-1:0] a_cnt;
    logic [BW-1:0] b_cnt;
    logic          computing;
    logic          restart;

    assign computing = (state == LSB) || (state == MID) || (state == MSB);
    // A new multiplication may only be launched from a non-computing state.
    assign restart   = start && !abort && !computing;

    // Sequencer: state and product counter, abort beats start, start while
    // computing is a protocol error.
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state <= IDLE;
            k     <= '0;
            a_cnt <= '0;
            b_cnt <= '0;
        end else if (abort) begin
            state <= IDLE;
            k     <= '0;
            a_cnt <= '0;
            b_cnt <= '0;
        end else if (restart) begin
            state <= LSB;
            k     <= '0;
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                LSB, MID: begin
                    if (start) begin
                        state <= ERR;
                    end else begin
                        k <= k + KW'(1);
                        if (a_cnt == A_LAST) begin
                            a_cnt <= '0;
                            b_cnt <= b_cnt + BW'(1);
                        end else begin
                            a_cnt <= a_cnt + AW'(1);
                        end
                        if (state == LSB) begin
                            state <= (NP == 2) ? MSB : MID;
                        end else begin
                            state <= (k == K_PENULT) ? MSB : MID;
                        end
                    end
                end
                MSB:       state <= start ? ERR : CALC_DONE;
                CALC_DONE: state <= IDLE;
                ERR:       state <= ERR;
                default:   state <= IDLE;
            endcase
        end
    end

    // Selects are forced to zero whenever no partial product is in flight.
    assign a_sel     = computing ? a_cnt : '0;
    assign b_sel     = computing ? b_cnt : '0;
    assign shift_sel = SW'(a_sel) + SW'(b_sel);

    assign state_out = state;
    assign done      = (state == CALC_DONE);
    assign busy      = computing;
    assign clk_ena   = computing;
    // Clear the accumulator in the same cycle the launch is accepted.
    assign sclr_n    = !restart;

endmodule
`default_nettype wire

// File: tb/tb_mult_control_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_control_n
//  Description : Directed self-checking bench for mult_control_n, default
//                2x2 slicing plus a 3x2 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_control_n;

    logic clk;
    logic reset_a;
    logic start0, abort0, start1, abort1;

    // Default instance (NA=2, NB=2): AW=1, BW=1, SW=2
    logic [0:0] a_sel0, b_sel0;
    logic [1:0] shift_sel0;
    logic [2:0] state_out0;
    logic       done0, busy0, clk_ena0, sclr_n0;

    // 3x2 instance: AW=2, BW=1, SW=2
    logic [1:0] a_sel1;
    logic [0:0] b_sel1;
    logic [1:0] shift_sel1;
    logic [2:0] state_out1;
    logic       done1, busy1, clk_ena1, sclr_n1;

    int checks = 0;
    int errors = 0;

    mult_control_n dut0 (
        .clk(clk), .reset_a(reset_a), .start(start0), .abort(abort0),
        .a_sel(a_sel0), .b_sel(b_sel0), .shift_sel(shift_sel0),
        .state_out(state_out0), .done(done0), .busy(busy0),
        .clk_ena(clk_ena0), .sclr_n(sclr_n0)
    );

    mult_control_n #(.SLICE_W(4), .NA(3), .NB(2)) dut1 (
        .clk(clk), .reset_a(reset_a), .start(start1), .abort(abort1),
        .a_sel(a_sel1), .b_sel(b_sel1), .shift_sel(shift_sel1),
        .state_out(state_out1), .done(done1), .busy(busy1),
        .clk_ena(clk_ena1), .sclr_n(sclr_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation vectors: {state, a, b, shift, done, busy, ena, sclr_n}
    logic [10:0] obs0;
    logic [11:0] obs1;
    assign obs0 = {state_out0, a_sel0, b_sel0, shift_sel0, done0, busy0, clk_ena0, sclr_n0};
    assign obs1 = {state_out1, a_sel1, b_sel1, shift_sel1, done1, busy1, clk_ena1, sclr_n1};

    function automatic logic [10:0] e0(input logic [2:0] st, input logic a, input logic b,
                                       input logic [1:0] sh, input logic d, input logic bz,
                                       input logic en, input logic sc);
        return {st, a, b, sh, d, bz, en, sc};
    endfunction

    function automatic logic [11:0] e1(input logic [2:0] st, input logic [1:0] a, input logic b,
                                       input logic [1:0] sh, input logic d, input logic bz,
                                       input logic en, input logic sc);
        return {st, a, b, sh, d, bz, en, sc};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the LSB cycle; checks the full default sequence and stops in CALC_DONE.
    task automatic run_seq0(input string tag);
        logic [10:0] ev [5];
        int ena_cnt;
        ev[0] = e0(3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        ev[1] = e0(3'd2, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        ev[2] = e0(3'd2, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        ev[3] = e0(3'd3, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        ev[4] = e0(3'd4, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        ena_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val($sformatf("%s_c%0d", tag, i), 16'(obs0), 16'(ev[i]));
            if (clk_ena0) ena_cnt++;
            if (i < 4) tick();
        end
        check_val({tag, "_ena_cycles"}, 16'(ena_cnt), 16'd4);
    endtask

    // 3x2 sequence: shift 0,1,2,1,2,3 then CALC_DONE on the 7th cycle after start.
    task automatic run_seq1(input string tag);
        logic [11:0] ev [7];
        int ena_cnt;
        ev[0] = e1(3'd1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        ev[1] = e1(3'd2, 2'd1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        ev[2] = e1(3'd2, 2'd2, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        ev[3] = e1(3'd2, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        ev[4] = e1(3'd2, 2'd1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        ev[5] = e1(3'd3, 2'd2, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        ev[6] = e1(3'd4, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        ena_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            check_val($sformatf("%s_c%0d", tag, i), 16'(obs1), 16'(ev[i]));
            if (clk_ena1) ena_cnt++;
            if (i < 6) tick();
        end
        check_val({tag, "_ena_cycles"}, 16'(ena_cnt), 16'd6);
    endtask

    logic [10:0] IDLE0;
    logic [11:0] IDLE1;

    initial begin
        IDLE0 = e0(3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        IDLE1 = e1(3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset_a = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;

        // Reset state, and sclr_n following start during reset
        #2;
        check_val("rst_dut0", 16'(obs0), 16'(IDLE0));
        check_val("rst_dut1", 16'(obs1), 16'(IDLE1));
        start0 = 1'b1;
        #1;
        check_val("rst_start_sclr", 16'(sclr_n0), 16'd0);
        start0 = 1'b0;
        @(negedge clk);
        reset_a = 1'b0;
        tick();

        // Basic sequence
        #1;
        check_val("t1_idle", 16'(obs0), 16'(IDLE0));
        start0 = 1'b1;
        #1;
        check_val("t1_launch", 16'(obs0), 16'(e0(3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        tick(); start0 = 1'b0;
        run_seq0("t1");
        tick();
        #1;
        check_val("t1_end_idle", 16'(obs0), 16'(IDLE0));

        // Back-to-back: relaunch during CALC_DONE
        start0 = 1'b1;
        tick(); start0 = 1'b0;
        run_seq0("t2a");
        start0 = 1'b1;
        #1;
        check_val("t2_done_sclr", 16'(obs0), 16'(e0(3'd4, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
        tick(); start0 = 1'b0;
        run_seq0("t2b");
        tick();
        #1;
        check_val("t2_end_idle", 16'(obs0), 16'(IDLE0));

        // Start during computation -> ERR, held, then recovery
        start0 = 1'b1;
        tick(); start0 = 1'b0;
        tick();
        start0 = 1'b1;
        #1;
        check_val("t3_mid", 16'(obs0), 16'(e0(3'd2, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1)));
        tick(); start0 = 1'b0;
        #1;
        check_val("t3_err", 16'(obs0), 16'(e0(3'd5, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1)));
        tick();
        #1;
        check_val("t3_err_hold", 16'(obs0), 16'(e0(3'd5, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1)));
        start0 = 1'b1;
        #1;
        check_val("t3_err_launch", 16'(obs0), 16'(e0(3'd5, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        tick(); start0 = 1'b0;
        run_seq0("t3");
        tick();

        // Abort in MSB, then abort+start in IDLE
        start0 = 1'b1;
        tick(); start0 = 1'b0;
        tick(); tick(); tick();
        #1;
        check_val("t4_msb", 16'(obs0), 16'(e0(3'd3, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1)));
        abort0 = 1'b1;
        tick(); abort0 = 1'b0;
        #1;
        check_val("t4_abort_idle", 16'(obs0), 16'(IDLE0));
        tick();
        #1;
        check_val("t4_no_done", 16'(obs0), 16'(IDLE0));
        abort0 = 1'b1; start0 = 1'b1;
        #1;
        check_val("t4_abort_start_sclr", 16'(obs0), 16'(IDLE0));
        tick(); abort0 = 1'b0; start0 = 1'b0;
        #1;
        check_val("t4_abort_start_idle", 16'(obs0), 16'(IDLE0));

        // 3x2 instance
        start1 = 1'b1;
        tick(); start1 = 1'b0;
        run_seq1("t5");
        tick();
        #1;
        check_val("t5_end_idle", 16'(obs1), 16'(IDLE1));

        // Asynchronous reset in MID
        start0 = 1'b1;
        tick(); start0 = 1'b0;
        tick();
        #1;
        check_val("t6_mid", 16'(obs0), 16'(e0(3'd2, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1)));
        #2 reset_a = 1'b1;
        #1;
        check_val("t6_async_rst", 16'(obs0), 16'(IDLE0));
        #2 reset_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check_val($sformatf("t6_post_rst_%0d", i), 16'(obs0), 16'(IDLE0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute runtime bound
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mult_control_n.md
MULT_CONTROL_N -- requirements
Module: mult_control_n

Interface
REQ-001 Parameter SLICE_W, default 4, bit width of one operand slice fed to the partial-product multiplier.
REQ-002 Parameter NA, default 2, number of slices of operand A (NA >= 1).
REQ-003 Parameter NB, default 2, number of slices of operand B (NB >= 1, NA*NB >= 2).
REQ-004 Derived widths SHALL be: AW = max(1, clog2(NA)), BW = max(1, clog2(NB)), SW = max(1, clog2(NA+NB-1)).
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset_a  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request to begin a multiplication, sampled each rising edge.
REQ-008 abort  input  1  cancel the in-progress multiplication, sampled each rising edge.
REQ-009 a_sel  output  AW  index of the A slice routed to the partial-product multiplier.
REQ-010 b_sel  output  BW  index of the B slice routed to the partial-product multiplier.
REQ-011 shift_sel  output  SW  partial-product left shift, in units of SLICE_W bits.
REQ-012 state_out  output  3  encoded current state.
REQ-013 done  output  1  one-cycle result-valid pulse.
REQ-014 busy  output  1  high while a multiplication is in progress.
REQ-015 clk_ena  output  1  accumulator register enable.
REQ-016 sclr_n  output  1  active-low synchronous clear for the accumulator.

Function
REQ-017 States SHALL be encoded as IDLE=000, LSB=001, MID=010, MSB=011, CALC_DONE=100, ERR=101; state_out SHALL equal the state register.
REQ-018 The block SHALL keep an internal product counter k, range 0..NA*NB-1, with a_sel = k mod NA, b_sel = k div NA, and shift_sel = a_sel + b_sel.
REQ-019 In IDLE, CALC_DONE or ERR with start=1 and abort=0: sclr_n=0 combinationally, k loads 0, next state is LSB.
REQ-020 LSB covers k=0; MID covers 0<k<NA*NB-1; MSB covers k=NA*NB-1; k increments by 1 on each edge in LSB/MID.
REQ-021 From LSB the next state is MSB when NA*NB=2, otherwise MID; from MID the next state is MSB when k=NA*NB-2.
REQ-022 From MSB the next state is CALC_DONE; CALC_DONE without start goes to IDLE, giving back-to-back operation with no idle cycle.
REQ-023 In LSB/MID/MSB: clk_ena=1, busy=1, done=0; in all other states clk_ena=0 and busy=0.
REQ-024 In CALC_DONE done=1 for exactly one cycle; done=0 in every other state.
REQ-025 start=1 in LSB, MID or MSB SHALL force ERR on the next edge, and the accumulator is not enabled in ERR.
REQ-026 abort=1 in any state SHALL force IDLE on the next edge, with k=0 and no done pulse; abort takes priority over start.
REQ-027 In ERR without start the state SHALL hold ERR.
REQ-028 Outside REQ-019, sclr_n=1; a_sel, b_sel and shift_sel SHALL read 0 in IDLE, CALC_DONE and ERR.

Reset
REQ-029 reset_a=1 SHALL immediately force state IDLE and k=0, independent of clk.
REQ-030 While in reset: state_out=000, a_sel=0, b_sel=0, shift_sel=0, done=0, busy=0, clk_ena=0, sclr_n=1 (sclr_n=0 only if start=1).
REQ-031 Reset asserted mid-operation SHALL abandon the operation with no done pulse; after release the block waits in IDLE for start.

Verification
REQ-032 Defaults, start=1 for one cycle from IDLE -> sclr_n=0 that cycle; then (a,b,shift) = (0,0,0) LSB, (1,0,1) MID, (0,1,1) MID, (1,1,2) MSB; then done=1 in CALC_DONE; then IDLE; clk_ena=1 for exactly 4 cycles.
REQ-033 Defaults, start re-asserted during CALC_DONE -> LSB next cycle with sclr_n=0 in CALC_DONE; second sequence identical to REQ-032.
REQ-034 Defaults, start=1 during first MID -> ERR (101), clk_ena=0, holds ERR; a later start -> LSB with a fresh full sequence.
REQ-035 Defaults, abort=1 in MSB -> IDLE next cycle, no done pulse; abort with start both high in IDLE -> stays IDLE.
REQ-036 NA=3, NB=2 -> 6 compute cycles with shift_sel sequence 0,1,2,1,2,3; done appears 7 cycles after start is sampled.
REQ-037 reset_a asserted asynchronously between edges in MID -> state_out=000 and busy=0 before the next edge; no done pulse follows.
